idct_mac_pe: RTL and testbench
==============================

# idct_mac_pe

Parametrised systolic multiply-accumulate element for the column/row IDCT datapath, successor to the fixed 8-point element. It computes one output sample as the dot product of an N-element input vector with an N-element signed coefficient vector, then applies rounding, arithmetic right shift and optional saturation. It adds valid/enable flow control, per-vector coefficients (a row can change every vector) and internal operand skewing, so callers present aligned vectors. A registered copy of each input vector is forwarded for chaining to the next element.

## Interface
- DW, 25, signed input sample width
- OW, 25, signed output sample width
- N, 8, transform points; legal values 4, 8, 16, 32
- CW, 8, signed coefficient width
- AW, DW+CW+$clog2(N), accumulator width (derived, not overridable)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- en  in  1  pipeline enable; 0 freezes every register
- in_valid  in  1  d_in/coef/shift qualify on this cycle
- d_in  in  N*DW  input vector, element k at [k*DW +: DW], signed
- coef  in  N*CW  coefficient vector, element k at [k*CW +: CW], signed
- shift  in  5  right-shift amount, 0..AW-1
- out_valid  out  1  d_out holds a new result
- d_out  out  OW  rounded, shifted result, signed
- prop_valid  out  1  d_prop is a new forwarded vector
- d_prop  out  N*DW  d_in registered one cycle

## Operation
- Define a vector as accepted at edge E0 when reset=0, en=1 and in_valid=1.
- Operand k (d_k, c_k) passes through a k-stage skew line before the MAC. Shift also rides a delay line of depth N, so every vector carries its own shift value.
- MAC chain:
  - stage 0: acc0 = d_0*c_0 at E0
  - stage k: acc_k = acc_(k-1) + d_k*c_k at E0+k
  - all products and sums are full precision in AW bits; no intermediate truncation
- Output stage at E0+N: r = (acc_(N-1) + rnd) >>> shift, where rnd = 0 if shift==0, else 1<<(shift-1). The shift is arithmetic.
- Narrowing r to OW: see Configuration.
- A valid bit travels with each stage. Stages whose valid is 0 still clock in data but do not assert out_valid.
- d_prop and prop_valid load d_in and in_valid at every en=1 edge. d_prop holds its value when in_valid=0; prop_valid drops.
- Behaviour with shift >= AW is undefined. The bench must not drive it.

## Timing
- Reset: every accumulator, skew register and valid bit clears to 0. out_valid=0, d_out=0, prop_valid=0, d_prop=0. Reset takes priority over en.
- Latency: a vector accepted at edge E0 produces d_out and out_valid=1 after edge E0+N. With en held high, that is N cycles.
- Throughput: one vector per cycle. Back-to-back in_valid yields back-to-back out_valid in the same order.
- out_valid is a one-cycle pulse per result. d_out holds the last result until the next valid result.
- en=0 for M cycles delays every in-flight result by exactly M cycles. No loss and no duplication. in_valid is ignored while en=0.
- Reset asserted mid-stream discards all in-flight vectors. No out_valid occurs until N edges after the first post-reset acceptance.
- prop latency is 1 cycle, independent of N.

## Configuration
- IDCT_PE_SAT_EN defined:
  - r saturates to [-2^(OW-1), 2^(OW-1)-1]
  - sat_flag is added as a 1-bit output, registered alongside d_out, high for saturated results
- IDCT_PE_SAT_EN undefined: d_out = r[OW-1:0] (two's-complement wrap) and no sat_flag port exists.

## Test plan
All scenarios use N=8, DW=OW=25 and coef={64,89,83,75,64,50,36,18} unless stated.
- Impulse: d_in={1,0,0,0,0,0,0,0}, shift=7 -> (64+64)>>>7 = 1; out_valid exactly 8 cycles after acceptance.
- All-ones: d_in all 1, shift=0 -> d_out=479. Then all -1, shift=0 -> d_out=-479.
- Rounding of negatives: d_0=-1, shift=7 -> 0. d_0=-3 -> (-192+64)>>>7 = -1.
- Streaming plus stall: 16 consecutive vectors with d_0=i (i=0..15), shift=0 -> 16 consecutive outputs 64*i. Deassert en for 3 cycles mid-stream -> same sequence, shifted 3 cycles.
- Saturation, OW=16: d_0=2^20, c_0=127, shift=0.
  - with IDCT_PE_SAT_EN: d_out=32767, sat_flag=1
  - without IDCT_PE_SAT_EN: d_out=0 (low 16 bits of 0x7F00000)
- Reset mid-stream: assert reset for 1 cycle while 5 vectors are in flight -> out_valid=0 and d_out=0 until a new vector completes. d_prop=0 and prop_valid=0 after the reset edge.

Source files
------------

// File: rtl/idct_mac_pe.sv
// Systolic multiply-accumulate element for the IDCT datapath: skewed N-term dot product,
// round, arithmetic shift, narrow. Define IDCT_PE_SAT_EN for saturation and a sat_flag output.
module idct_mac_pe #(
  parameter int DW = 25,
  parameter int OW = 25,
  parameter int N  = 8,
  parameter int CW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              in_valid,
  input  logic [N*DW-1:0]   d_in,
  input  logic [N*CW-1:0]   coef,
  input  logic [4:0]        shift,
  output logic              out_valid,
  output logic [OW-1:0]     d_out,
`ifdef IDCT_PE_SAT_EN
  output logic              sat_flag,
`endif
  output logic              prop_valid,
  output logic [N*DW-1:0]   d_prop
);

  localparam int AW = DW + CW + $clog2(N);
  localparam int PW = DW + CW;

  // Flow control: a vector is taken on an edge with en=1 and in_valid=1. en=0 freezes every
  // register, out_valid included, so a consumer takes a result on an edge where out_valid=1 and en=1.

  logic signed [DW-1:0] op_d   [N];
  logic signed [CW-1:0] op_c   [N];
  logic signed [PW-1:0] prod   [N];
  logic signed [AW-1:0] prod_x [N];

  logic signed [AW-1:0] acc_q [N];
  logic                 v_q   [N];
  logic [4:0]           sh_q  [N];

  logic                 out_valid_q;
  logic [OW-1:0]        d_out_q;
  logic [OW-1:0]        res_d;
  logic                 prop_valid_q;
  logic [N*DW-1:0]      d_prop_q;

  logic [AW:0]          rnd;
  logic signed [AW:0]   sum;

  // Lane k delays its operands by k edges so term k meets the accumulator at stage k.
  for (genvar k = 0; k < N; k++) begin : g_lane
    if (k == 0) begin : g_direct
      assign op_d[k] = d_in[k*DW +: DW];
      assign op_c[k] = coef[k*CW +: CW];
    end else begin : g_skew
      logic signed [DW-1:0] dsk_q [k];
      logic signed [CW-1:0] csk_q [k];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int j = 0; j < k; j++) begin
            dsk_q[j] <= '0;
            csk_q[j] <= '0;
          end
        end else if (en) begin
          dsk_q[0] <= d_in[k*DW +: DW];
          csk_q[0] <= coef[k*CW +: CW];
          for (int j = 1; j < k; j++) begin
            dsk_q[j] <= dsk_q[j-1];
            csk_q[j] <= csk_q[j-1];
          end
        end
      end

      assign op_d[k] = dsk_q[k-1];
      assign op_c[k] = csk_q[k-1];
    end

    assign prod[k]   = op_d[k] * op_c[k];
    assign prod_x[k] = {{(AW-PW){prod[k][PW-1]}}, prod[k]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        acc_q[k] <= '0;
        v_q[k]   <= 1'b0;
        sh_q[k]  <= '0;
      end
      out_valid_q  <= 1'b0;
      d_out_q      <= '0;
      prop_valid_q <= 1'b0;
      d_prop_q     <= '0;
    end else if (en) begin
      acc_q[0] <= prod_x[0];
      v_q[0]   <= in_valid;
      sh_q[0]  <= shift;
      for (int k = 1; k < N; k++) begin
        acc_q[k] <= acc_q[k-1] + prod_x[k];
        v_q[k]   <= v_q[k-1];
        sh_q[k]  <= sh_q[k-1];
      end
      out_valid_q  <= v_q[N-1];
      if (v_q[N-1]) d_out_q <= res_d;
      prop_valid_q <= in_valid;
      if (in_valid) d_prop_q <= d_in;
    end
  end

`ifdef IDCT_PE_SAT_EN
  localparam logic signed [AW:0] MAX_V = {{(AW+2-OW){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW:0] MIN_V = ~MAX_V;

  logic signed [AW:0] r;
  logic               sat_d;
  logic               sat_flag_q;

  always_comb begin
    rnd = '0;
    if (sh_q[N-1] != 5'd0) rnd = {{AW{1'b0}}, 1'b1} << (sh_q[N-1] - 5'd1);
    sum   = {acc_q[N-1][AW-1], acc_q[N-1]} + rnd;
    r     = sum >>> sh_q[N-1];
    sat_d = 1'b0;
    res_d = r[OW-1:0];
    if (r > MAX_V) begin
      res_d = MAX_V[OW-1:0];
      sat_d = 1'b1;
    end else if (r < MIN_V) begin
      res_d = MIN_V[OW-1:0];
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_flag_q <= 1'b0;
    end else if (en && v_q[N-1]) begin
      sat_flag_q <= sat_d;
    end
  end

  assign sat_flag = sat_flag_q;
`else
  // Extra sign bit keeps the rounding add from overflowing before the shift.
  always_comb begin
    rnd = '0;
    if (sh_q[N-1] != 5'd0) rnd = {{AW{1'b0}}, 1'b1} << (sh_q[N-1] - 5'd1);
    sum   = {acc_q[N-1][AW-1], acc_q[N-1]} + rnd;
    res_d = OW'(sum >>> sh_q[N-1]);
  end
`endif

  assign out_valid  = out_valid_q;
  assign d_out      = d_out_q;
  assign prop_valid = prop_valid_q;
  assign d_prop     = d_prop_q;

endmodule

// File: tb/tb_idct_mac_pe.sv
// Scoreboard bench for idct_mac_pe: random and directed vectors, stalls and resets,
// checked against a plain-arithmetic dot-product model.
module tb_idct_mac_pe;
  localparam int DW = 25;
  localparam int OW = 25;
  localparam int N  = 8;
  localparam int CW = 8;

  logic              clk;
  logic              reset;
  logic              en;
  logic              in_valid;
  logic [N*DW-1:0]   d_in;
  logic [N*CW-1:0]   coef;
  logic [4:0]        shift;
  logic              out_valid;
  logic [OW-1:0]     d_out;
  logic              prop_valid;
  logic [N*DW-1:0]   d_prop;
`ifdef IDCT_PE_SAT_EN
  logic              sat_flag;
`endif

  idct_mac_pe #(.DW(DW), .OW(OW), .N(N), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .in_valid   (in_valid),
    .d_in       (d_in),
    .coef       (coef),
    .shift      (shift),
    .out_valid  (out_valid),
    .d_out      (d_out),
`ifdef IDCT_PE_SAT_EN
    .sat_flag   (sat_flag),
`endif
    .prop_valid (prop_valid),
    .d_prop     (d_prop)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [OW-1:0]   exp_q[$];
  int              tag_q[$];
  bit              sat_q[$];
  int              checks;
  int              errors;
  int              en_cnt;
  int              rst_cnt;
  bit              started;
  bit              stim_done;
  logic [N*DW-1:0] exp_prop;
  logic            exp_pv;

  bit              drv_has_exp;
  logic [OW-1:0]   drv_exp;
  bit              drv_exp_sat;

  int cstd [N] = '{64, 89, 83, 75, 64, 50, 36, 18};

  // ---------------- reference model ----------------
  function automatic logic [OW-1:0] ref_out(input logic [N*DW-1:0] d, input logic [N*CW-1:0] c,
                                            input logic [4:0] sh, output bit sat);
    longint acc, rnd, r, hi, lo;
    logic signed [DW-1:0] dv;
    logic signed [CW-1:0] cv;
    logic [63:0] rb;
    acc = 0;
    for (int k = 0; k < N; k++) begin
      dv = d[k*DW +: DW];
      cv = c[k*CW +: CW];
      acc += longint'(dv) * longint'(cv);
    end
    rnd = (sh == 0) ? 64'sd0 : (longint'(1) << (sh - 1));
    r   = (acc + rnd) >>> sh;
    hi  = (longint'(1) << (OW - 1)) - 1;
    lo  = -hi - 1;
    sat = 1'b0;
`ifdef IDCT_PE_SAT_EN
    if (r > hi) begin r = hi; sat = 1'b1; end
    else if (r < lo) begin r = lo; sat = 1'b1; end
`endif
    rb = r;
    return rb[OW-1:0];
  endfunction

  function automatic logic [N*CW-1:0] coef_std();
    logic [N*CW-1:0] c;
    for (int k = 0; k < N; k++) c[k*CW +: CW] = CW'(cstd[k]);
    return c;
  endfunction

  function automatic logic [N*DW-1:0] vec_d0(input int v0, input int rest);
    logic [N*DW-1:0] d;
    for (int k = 0; k < N; k++) d[k*DW +: DW] = DW'((k == 0) ? v0 : rest);
    return d;
  endfunction

  function automatic logic [N*DW-1:0] rand_d();
    logic [N*DW-1:0] d;
    logic [31:0] u;
    int s;
    for (int k = 0; k < N; k++) begin
      u = $urandom();
      s = int'($urandom_range(0, 2000)) - 1000;
      d[k*DW +: DW] = ($urandom_range(0, 3) == 0) ? u[DW-1:0] : DW'(s);
    end
    return d;
  endfunction

  function automatic logic [N*CW-1:0] rand_c();
    logic [N*CW-1:0] c;
    logic [31:0] u;
    for (int k = 0; k < N; k++) begin
      u = $urandom();
      c[k*CW +: CW] = u[CW-1:0];
    end
    return c;
  endfunction

  // Acceptance tracker: each taken vector is due on the (en_cnt+N)-th enabled edge.
  always @(posedge clk) begin
    logic [OW-1:0] v;
    bit s;
    if (reset) begin
      exp_q.delete();
      tag_q.delete();
      sat_q.delete();
      exp_prop = '0;
      exp_pv   = 1'b0;
      rst_cnt++;
      started  = 1'b1;
    end else if (en) begin
      en_cnt++;
      exp_pv = in_valid;
      if (in_valid) begin
        exp_prop = d_in;
        v = ref_out(d_in, coef, shift, s);
        if (drv_has_exp) begin
          v = drv_exp;
          s = drv_exp_sat;
        end
        exp_q.push_back(v);
        tag_q.push_back(en_cnt + N);
        sat_q.push_back(s);
      end
    end
  end

  // ---------------- monitor / checker ----------------
  int            rst_seen;
  logic [OW-1:0] last_dout;
  bit            reported;

  always @(negedge clk) begin
    if (started && !reported) begin
      if (rst_seen != rst_cnt) begin
        rst_seen  = rst_cnt;
        last_dout = '0;
      end
      checks++;
      if (prop_valid !== exp_pv) begin
        errors++;
        $display("FAIL prop_valid: got %b expected %b at %0t", prop_valid, exp_pv, $time);
      end
      checks++;
      if (d_prop !== exp_prop) begin
        errors++;
        $display("FAIL d_prop: got %h expected %h at %0t", d_prop, exp_prop, $time);
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_out_valid: got out_valid=1 with d_out=%0d, expected none at %0t",
                   $signed(d_out), $time);
        end else begin
          if (d_out !== exp_q[0] || tag_q[0] != en_cnt) begin
            errors++;
            $display("FAIL result: got d_out=%0d at edge %0d expected %0d at edge %0d (t=%0t)",
                     $signed(d_out), en_cnt, $signed(exp_q[0]), tag_q[0], $time);
          end
`ifdef IDCT_PE_SAT_EN
          checks++;
          if (sat_flag !== sat_q[0]) begin
            errors++;
            $display("FAIL sat_flag: got %b expected %b at %0t", sat_flag, sat_q[0], $time);
          end
`endif
          if (en && !reset) begin
            last_dout = exp_q.pop_front();
            void'(tag_q.pop_front());
            void'(sat_q.pop_front());
          end
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0 || d_out !== last_dout) begin
          errors++;
          $display("FAIL idle_output: got out_valid=%b d_out=%0d expected 0 and %0d at %0t",
                   out_valid, $signed(d_out), $signed(last_dout), $time);
        end
        if (tag_q.size() > 0 && tag_q[0] <= en_cnt) begin
          checks++;
          errors++;
          $display("FAIL missing_result: got out_valid=0 expected %0d due at edge %0d (t=%0t)",
                   $signed(exp_q[0]), tag_q[0], $time);
          void'(exp_q.pop_front());
          void'(tag_q.pop_front());
          void'(sat_q.pop_front());
        end
      end
      if (stim_done) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL drain: got %0d results outstanding expected 0", exp_q.size());
        end
        reported = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish by 200000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [N*DW-1:0] d, input logic [N*CW-1:0] c, input logic [4:0] sh,
                      input bit has_exp, input logic [OW-1:0] ev, input bit es);
    en = 1'b1; in_valid = 1'b1; d_in = d; coef = c; shift = sh;
    drv_has_exp = has_exp; drv_exp = ev; drv_exp_sat = es;
    @(posedge clk); #1;
    in_valid = 1'b0; drv_has_exp = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      en = 1'b1; in_valid = 1'b0; d_in = rand_d(); shift = 5'($urandom_range(0, 24));
      @(posedge clk); #1;
    end
  endtask

  task automatic stall(input int n);
    repeat (n) begin
      en = 1'b0; in_valid = 1'b1; d_in = rand_d(); coef = rand_c();
      @(posedge clk); #1;
    end
    en = 1'b1; in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; en = 1'b0; in_valid = 1'b1; d_in = rand_d();
    @(posedge clk); #1;
    reset = 1'b0; en = 1'b1; in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N*CW-1:0] cs;
    logic [N*CW-1:0] cw;
    int r;
    checks = 0; errors = 0; en_cnt = 0; rst_cnt = 0; rst_seen = 0;
    started = 0; stim_done = 0; reported = 0; last_dout = '0;
    exp_prop = '0; exp_pv = 1'b0;
    drv_has_exp = 0; drv_exp = '0; drv_exp_sat = 0;
    reset = 1'b1; en = 1'b0; in_valid = 1'b0; d_in = '0; coef = '0; shift = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    cs = coef_std();
    idle(2);

    // impulse, all-ones, negatives with rounding
    send(vec_d0(1, 0), cs, 5'd7, 1, OW'(1), 0);
    idle(N + 2);
    send(vec_d0(1, 1), cs, 5'd0, 1, OW'(479), 0);
    send(vec_d0(-1, -1), cs, 5'd0, 1, OW'(-479), 0);
    send(vec_d0(-1, 0), cs, 5'd7, 1, OW'(0), 0);
    send(vec_d0(-3, 0), cs, 5'd7, 1, OW'(-1), 0);
    idle(N + 2);

    // streaming with a 3-cycle stall in the middle
    for (int i = 0; i < 16; i++) begin
      if (i == 8) stall(3);
      send(vec_d0(i, 0), cs, 5'd0, 1, OW'(64 * i), 0);
    end
    idle(N + 2);

    // overflow of the output width: wraps, or clamps with saturation
    cw = cs;
    cw[0 +: CW] = 8'd127;
`ifdef IDCT_PE_SAT_EN
    send(vec_d0((1 << 24) - 1, 0), cw, 5'd0, 1, OW'((1 << 24) - 1), 1);
`else
    send(vec_d0((1 << 24) - 1, 0), cw, 5'd0, 1, OW'(24'hFFFF81), 0);
`endif
    idle(N + 2);

    // reset while five vectors are in flight
    for (int i = 0; i < 5; i++) send(rand_d(), cs, 5'd3, 0, '0, 0);
    pulse_reset();
    idle(N + 3);
    send(vec_d0(1, 0), cs, 5'd7, 1, OW'(1), 0);
    idle(N + 2);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8) stall(int'($urandom_range(1, 3)));
      else if (r < 10) pulse_reset();
      else if (r < 75) send(rand_d(), rand_c(), 5'($urandom_range(0, 24)), 0, '0, 0);
      else idle(1);
    end
    idle(N + 4);
    stim_done = 1'b1;
  end

endmodule
